// File: rtl/uart_rx_os16_pkg.sv
// Shared constants, state encoding and helpers for the 16x oversampling UART receiver.
package uart_rx_os16_pkg;

    localparam int         DATA_WIDTH = 8;
    localparam int         OS_RATE    = 16;
    localparam logic [3:0] OS_MID     = 4'd7;
    localparam logic [3:0] OS_LAST    = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Receiver-side control and byte handshake bundle.
interface uart_rx_os16_if;
    import uart_rx_os16_pkg::*;

    logic                  i_rx;
    logic                  i_rx_serial;
    logic                  i_rx_ack;
    logic [DATA_WIDTH-1:0] o_rx_byte;
    logic                  o_rx_d;
    logic                  o_rx_valid;
    logic                  o_frame_err;
    logic                  o_overrun;
    logic                  o_busy;

    modport master (
        output i_rx, i_rx_serial, i_rx_ack,
        input  o_rx_byte, o_rx_d, o_rx_valid, o_frame_err, o_overrun, o_busy
    );

    modport slave (
        input  i_rx, i_rx_serial, i_rx_ack,
        output o_rx_byte, o_rx_d, o_rx_valid, o_frame_err, o_overrun, o_busy
    );

endinterface

// File: rtl/uart_rx_os16_baud_tick.sv
// Oversample tick generator: one-cycle tick every TICK_DIV sysclk cycles, phase reset by i_clr.
module uart_baud_tick #(
    parameter int TICK_DIV = 68
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (i_clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign o_tick = !i_clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote per bit.
module uart_rx_os16
    import uart_rx_os16_pkg::*;
#(
    parameter int CLK_FREQ = 125_000_000,
    parameter int BAUD     = 115200,
    parameter int TICK_DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16)
) (
    input  logic           sysclk,
    input  logic           rst_n,
    uart_rx_os16_if.slave  rx_if
);

    localparam int                OSW     = $clog2(OS_RATE);
    localparam int                BIW     = $clog2(DATA_WIDTH);
    localparam logic [OSW-1:0]    OS_S1   = OS_MID + 4'd1;
    localparam logic [OSW-1:0]    OS_DEC  = OS_MID + 4'd2;
    localparam logic [BIW-1:0]    BIT_END = BIW'(DATA_WIDTH - 1);

    rx_state_t             state, state_nx;
    logic                  sync1, rxs, rxs_d, fall;
    logic                  tick, clr_tick, decide, bit_end, maj;
    logic [OSW-1:0]        os;
    logic [BIW-1:0]        bit_idx;
    logic                  s7, s8;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  busy, shift_en, good, bad;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  rx_d, rx_valid, frame_err, overrun;

    // Synchronizers reset to 1 so release from reset never looks like a start edge.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= rx_if.i_rx_serial;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    assign fall = rxs_d & ~rxs;

    // Held clear while idle so the first tick lands TICK_DIV cycles after the start edge.
    assign clr_tick = (state == ST_IDLE);

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .i_clr  (clr_tick),
        .o_tick (tick)
    );

    assign decide  = tick && (os == OS_DEC);
    assign bit_end = tick && (os == OS_LAST);
    assign maj     = maj3(s7, s8, rxs);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!rx_if.i_rx) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (fall) state_nx = ST_START;
                ST_START: begin
                    if (decide && maj)
                        state_nx = ST_IDLE;
                    else if (bit_end)
                        state_nx = ST_DATA;
                end
                ST_DATA:  if (bit_end && bit_idx == BIT_END) state_nx = ST_STOP;
                // Leaving at mid-stop lets a back-to-back start edge be caught.
                ST_STOP:  if (decide) state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        shift_en = 1'b0;
        good     = 1'b0;
        bad      = 1'b0;
        if (rx_if.i_rx) begin
            shift_en = (state == ST_DATA) && decide;
            good     = (state == ST_STOP) && decide && maj;
            bad      = (state == ST_STOP) && decide && !maj;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            os      <= '0;
            bit_idx <= '0;
            s7      <= 1'b1;
            s8      <= 1'b1;
            shreg   <= '0;
        end else begin
            if (state == ST_IDLE)
                os <= '0;
            else if (tick)
                os <= os + OSW'(1);

            if (state != ST_DATA)
                bit_idx <= '0;
            else if (bit_end)
                bit_idx <= bit_idx + BIW'(1);

            if (tick && os == OS_MID) s7 <= rxs;
            if (tick && os == OS_S1)  s8 <= rxs;

            if (shift_en)
                shreg <= {maj, shreg[DATA_WIDTH-1:1]};
        end
    end

    // A new byte wins over a same-cycle ack, and that ack also suppresses the overrun.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_byte   <= '0;
            rx_d      <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_d      <= good;
            frame_err <= bad;
            overrun   <= good && rx_valid && !rx_if.i_rx_ack;
            if (good) begin
                rx_byte  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_if.i_rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_if.o_rx_byte   = rx_byte;
    assign rx_if.o_rx_d      = rx_d;
    assign rx_if.o_rx_valid  = rx_valid;
    assign rx_if.o_frame_err = frame_err;
    assign rx_if.o_overrun   = overrun;
    assign rx_if.o_busy      = busy;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed + randomized bench for uart_rx_os16 with a frame-level scoreboard.
module tb_uart_rx_os16;
    import uart_rx_os16_pkg::*;

    localparam int TD  = 4;
    localparam int BIT = 16 * TD;
    // Stop-bit decision is 9 bit periods + 10 ticks after START entry; +3 for sync and edge detect.
    localparam int LAT = 9 * BIT + 10 * TD + 3;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 sysclk = ~sysclk;

    uart_rx_os16_if bus();

    uart_rx_os16 #(.CLK_FREQ(125_000_000), .BAUD(115200), .TICK_DIV(TD)) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .rx_if  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int n_d = 0, n_fe = 0, n_ov = 0, busy_cnt = 0, last_d_cyc = 0;
    always @(negedge sysclk) begin
        if (bus.o_rx_d)      begin n_d  <= n_d + 1; last_d_cyc <= cyc; end
        if (bus.o_frame_err) n_fe <= n_fe + 1;
        if (bus.o_overrun)   n_ov <= n_ov + 1;
        if (bus.o_busy)      busy_cnt <= busy_cnt + 1;
    end

    // Frame-level reference model
    int   m_byte = 0, m_nd = 0, m_nfe = 0, m_nov = 0;
    logic m_valid = 1'b0;
    int   start_cyc = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, "_byte"},  int'(bus.o_rx_byte), m_byte);
        chk({tag, "_valid"}, int'(bus.o_rx_valid), int'(m_valid));
        chk({tag, "_nd"},    n_d,  m_nd);
        chk({tag, "_nfe"},   n_fe, m_nfe);
        chk({tag, "_nov"},   n_ov, m_nov);
    endtask

    function automatic void model_good(input int b, input logic ack_same);
        if (m_valid && !ack_same) m_nov++;
        m_valid = 1'b1;
        m_byte  = b;
        m_nd++;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic ack();
        bus.i_rx_ack = 1'b1;
        idle(1);
        bus.i_rx_ack = 1'b0;
        m_valid = 1'b0;
    endtask

    // One bit period; gs corrupts the line around one sample point, act aborts mid-bit.
    task automatic drive_bit(input logic v, input int gs, input int act);
        for (int i = 0; i < BIT; i++) begin
            bus.i_rx_serial = (gs >= 0 && i >= gs - 2 && i <= gs + 1) ? ~v : v;
            if (act != 0 && i == 32) begin
                if (act == 1) bus.i_rx = 1'b0;
                else          rst_n = 1'b0;
            end
            if (act != 0 && i == 40) begin
                chk("abort_busy", int'(bus.o_busy), 0);
                if (act == 2) rst_n = 1'b1;
            end
            idle(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gbit,
                              input int gs, input int act);
        start_cyc = cyc;
        drive_bit(1'b0, -1, 0);
        for (int k = 0; k < 8; k++)
            drive_bit(b[k], (k == gbit) ? gs : -1, (k == 4) ? act : 0);
        drive_bit(stop, -1, 0);
        bus.i_rx_serial = 1'b1;
    endtask

    initial begin
        int b0, lat, d;
        bus.i_rx = 1'b0;
        bus.i_rx_serial = 1'b1;
        bus.i_rx_ack = 1'b0;
        idle(3);
        cmp_all("reset");
        chk("reset_busy", int'(bus.o_busy), 0);
        rst_n = 1'b1;
        bus.i_rx = 1'b1;
        idle(10);

        // Test 1: plain frame, latency window
        send_frame(8'hA5, 1'b1, -1, -1, 0);
        model_good(8'hA5, 1'b0);
        idle(10);
        cmp_all("t1");
        lat = last_d_cyc - start_cyc;
        chk("t1_latency_in_window", int'(lat >= LAT - 4 && lat <= LAT + 4), 1);

        // Test 3: 20-cycle low glitch on idle line
        b0 = busy_cnt;
        bus.i_rx_serial = 1'b0;
        idle(20);
        bus.i_rx_serial = 1'b1;
        idle(100);
        d = busy_cnt - b0;
        cmp_all("t3");
        chk("t3_busy_le40", int'(d > 0 && d <= 40), 1);

        // Test 4: bad stop bit keeps the previous byte
        ack();
        send_frame(8'h55, 1'b0, -1, -1, 0);
        m_nfe++;
        idle(10);
        cmp_all("t4");

        // Test 2: one wrong sample (os=8) in bit 2
        send_frame(8'h3C, 1'b1, 2, 36, 0);
        model_good(8'h3C, 1'b0);
        idle(10);
        cmp_all("t2");

        // Test 5a: back-to-back without ack -> overrun
        ack();
        send_frame(8'h01, 1'b1, -1, -1, 0);
        model_good(8'h01, 1'b0);
        send_frame(8'h02, 1'b1, -1, -1, 0);
        model_good(8'h02, 1'b0);
        idle(10);
        cmp_all("t5a");

        // Test 5b: ack in the cycle the second byte lands -> no overrun
        ack();
        send_frame(8'h01, 1'b1, -1, -1, 0);
        model_good(8'h01, 1'b0);
        fork
            send_frame(8'h02, 1'b1, -1, -1, 0);
            begin
                idle(LAT - 1);
                bus.i_rx_ack = 1'b1;
                idle(1);
                bus.i_rx_ack = 1'b0;
            end
        join
        model_good(8'h02, 1'b1);
        idle(10);
        cmp_all("t5b");

        // Test 6a: receiver disabled during bit 4
        ack();
        send_frame(8'hFF, 1'b1, -1, -1, 1);
        bus.i_rx = 1'b1;
        idle(10);
        cmp_all("t6a");
        send_frame(8'h81, 1'b1, -1, -1, 0);
        model_good(8'h81, 1'b0);
        idle(10);
        cmp_all("t6a_next");

        // Test 6b: reset pulse during bit 4
        send_frame(8'hFF, 1'b1, -1, -1, 2);
        m_byte = 0;
        m_valid = 1'b0;
        idle(10);
        cmp_all("t6b");
        send_frame(8'h81, 1'b1, -1, -1, 0);
        model_good(8'h81, 1'b0);
        idle(10);
        cmp_all("t6b_next");

        // Randomized frames: random data, one corrupted sample, random ack
        for (int r = 0; r < 6; r++) begin
            logic [7:0] rb;
            int gb, gsmp;
            rb   = 8'($urandom);
            gb   = int'($urandom_range(0, 7));
            gsmp = 32 + 4 * int'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) ack();
            send_frame(rb, 1'b1, gb, gsmp, 0);
            model_good(int'(rb), 1'b0);
            idle(int'($urandom_range(2, 30)));
            cmp_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
